// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: S-box tables, layer functions and key-schedule steps
// used by both the encryption and decryption cores.
package present_pkg;

    localparam int unsigned ROUNDS = 31;
    localparam int unsigned KEY_W  = 80;
    localparam int unsigned BLK_W  = 64;
    localparam int unsigned RND_W  = 5;

    // Nibble i of each table holds the mapping for input value i.
    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2,
        DONE    = 2'd3
    } dec_fsm_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [BLK_W-1:0] inv_slayer(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = inv_sbox(s[4*i +: 4]);
        end
        return r;
    endfunction

    // Inverse bit permutation: bit j returns to position 4*j mod 63; bit 63 is fixed.
    function automatic logic [BLK_W-1:0] inv_player(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int j = 0; j < 63; j++) begin
            r[(4*j) % 63] = s[j];
        end
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] ks_fwd(input logic [KEY_W-1:0] key,
                                                 input logic [RND_W-1:0] rnd);
        logic [KEY_W-1:0] t;
        t = {key[18:0], key[79:19]};
        return {sbox(t[79:76]), t[75:20], t[19:15] ^ rnd, t[14:0]};
    endfunction

    function automatic logic [KEY_W-1:0] ks_inv(input logic [KEY_W-1:0] key,
                                                 input logic [RND_W-1:0] rnd);
        logic [KEY_W-1:0] u;
        u          = key;
        u[19:15]   = u[19:15] ^ rnd;
        u[79:76]   = inv_sbox(u[79:76]);
        return {u[60:0], u[79:61]};
    endfunction

endpackage

// File: rtl/present_inv_round.sv
// One PRESENT-80 inverse round: strips the current round key from the state and
// walks the key register back one schedule step.
module present_inv_round
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] state,
    input  logic [KEY_W-1:0] key,
    input  logic [RND_W-1:0] rnd,
    output logic [BLK_W-1:0] nextstate,
    output logic [KEY_W-1:0] nextkey
);

    always_comb begin
        nextstate = inv_slayer(inv_player(state ^ key[KEY_W-1 -: BLK_W]));
        nextkey   = ks_inv(key, rnd);
    end

endmodule

// File: rtl/present_dec.sv
// Iterative PRESENT-80 decryptor: forward key expansion to K32, then 31 inverse rounds
// at one per clock, with an optional one-entry cache of the last key's K32.
module present_dec
    import present_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  mkey,
    input  logic [BLK_W-1:0]  ciphertext,
    output logic              busy,
    output logic              done,
    output logic [BLK_W-1:0]  plaintext
);

    dec_fsm_e          fsm, fsm_nxt;
    logic [RND_W-1:0]  rnd, rnd_nxt;
    logic [BLK_W-1:0]  blk, blk_nxt;
    logic [KEY_W-1:0]  key, key_nxt;
    logic              busy_nxt, done_nxt;
    logic [BLK_W-1:0]  plaintext_nxt;

    // Key being expanded is held until expansion completes so the cache entry stays coherent.
    logic [KEY_W-1:0]  pend_mkey, pend_mkey_nxt;
    logic              cache_vld, cache_vld_nxt;
    logic [KEY_W-1:0]  cache_mkey, cache_mkey_nxt;
    logic [KEY_W-1:0]  cache_k32, cache_k32_nxt;

    logic [BLK_W-1:0]  inv_state;
    logic [KEY_W-1:0]  inv_key;
    logic              accept_c;
    logic              hit_c;

    present_inv_round u_inv_round (
        .state     (blk),
        .key       (key),
        .rnd       (rnd),
        .nextstate (inv_state),
        .nextkey   (inv_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            rnd        <= '0;
            blk        <= '0;
            key        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            plaintext  <= '0;
            pend_mkey  <= '0;
            cache_vld  <= 1'b0;
            cache_mkey <= '0;
            cache_k32  <= '0;
        end else begin
            fsm        <= fsm_nxt;
            rnd        <= rnd_nxt;
            blk        <= blk_nxt;
            key        <= key_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            plaintext  <= plaintext_nxt;
            pend_mkey  <= pend_mkey_nxt;
            cache_vld  <= cache_vld_nxt;
            cache_mkey <= cache_mkey_nxt;
            cache_k32  <= cache_k32_nxt;
        end
    end

    always_comb begin
        fsm_nxt        = fsm;
        rnd_nxt        = rnd;
        blk_nxt        = blk;
        key_nxt        = key;
        busy_nxt       = busy;
        done_nxt       = done;
        plaintext_nxt  = plaintext;
        pend_mkey_nxt  = pend_mkey;
        cache_vld_nxt  = cache_vld;
        cache_mkey_nxt = cache_mkey;
        cache_k32_nxt  = cache_k32;

        accept_c = start && ((fsm == IDLE) || (fsm == DONE));
        hit_c    = KEY_CACHE && cache_vld && (mkey == cache_mkey);

        case (fsm)
            IDLE, DONE: begin
                if (accept_c) begin
                    blk_nxt  = ciphertext;
                    done_nxt = 1'b0;
                    busy_nxt = 1'b1;
                    if (hit_c) begin
                        key_nxt = cache_k32;
                        rnd_nxt = RND_W'(ROUNDS);
                        fsm_nxt = DECRYPT;
                    end else begin
                        key_nxt       = mkey;
                        pend_mkey_nxt = mkey;
                        rnd_nxt       = RND_W'(1);
                        fsm_nxt       = EXPAND;
                    end
                end
            end

            EXPAND: begin
                key_nxt = ks_fwd(key, rnd);
                rnd_nxt = rnd + RND_W'(1);
                // Final step lands on K32; decryption starts from the top round.
                if (rnd == RND_W'(ROUNDS)) begin
                    rnd_nxt = RND_W'(ROUNDS);
                    fsm_nxt = DECRYPT;
                    if (KEY_CACHE) begin
                        cache_vld_nxt  = 1'b1;
                        cache_mkey_nxt = pend_mkey;
                        cache_k32_nxt  = key_nxt;
                    end
                end
            end

            DECRYPT: begin
                blk_nxt = inv_state;
                key_nxt = inv_key;
                rnd_nxt = rnd - RND_W'(1);
                // After round 1 the key register holds K1 for the output whitening.
                if (rnd == RND_W'(1)) begin
                    plaintext_nxt = inv_state ^ inv_key[KEY_W-1 -: BLK_W];
                    done_nxt      = 1'b1;
                    busy_nxt      = 1'b0;
                    fsm_nxt       = DONE;
                end
            end

            default: begin
                fsm_nxt  = IDLE;
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_present_dec.sv
// Scoreboard bench for present_dec: stimulus pushes expected plaintext/latency,
// a negedge monitor pops and checks on each rising done.
module tb_present_dec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_nc;
    logic [79:0] mkey;
    logic [63:0] ciphertext;
    logic        busy, done, busy_nc, done_nc;
    logic [63:0] plaintext, pt_nc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [63:0] pt;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic done_prev[2];
    int   busy_cnt[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    present_dec #(.KEY_CACHE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mkey(mkey), .ciphertext(ciphertext),
        .busy(busy), .done(done), .plaintext(plaintext)
    );

    present_dec #(.KEY_CACHE(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .start(start_nc), .mkey(mkey), .ciphertext(ciphertext),
        .busy(busy_nc), .done(done_nc), .plaintext(pt_nc)
    );

    // ---------------- independent forward encryption model ----------------
    function automatic logic [3:0] m_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] k_in);
        logic [63:0] s, p;
        logic [79:0] k;
        s = pt;
        k = k_in;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int i = 0; i < 16; i++) s[4*i +: 4] = m_sbox(s[4*i +: 4]);
            p = '0;
            for (int i = 0; i < 63; i++) p[(16*i) % 63] = s[i];
            p[63] = s[63];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = m_sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_step(input int s, input logic d, input logic b, input logic [63:0] p);
        exp_t e;
        if (b) busy_cnt[s]++;
        if (d && !done_prev[s]) begin
            if ((s == 0 ? q0.size() : q1.size()) == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: inst %0d got done with no pending op", s);
            end else begin
                e = (s == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("plaintext[%0d]", s), 80'(p), 80'(e.pt));
                check($sformatf("latency[%0d]", s), 80'(cyc - e.acc), 80'(e.lat));
                check($sformatf("busy_cycles[%0d]", s), 80'(busy_cnt[s]), 80'(e.lat));
            end
            busy_cnt[s] = 0;
        end
        done_prev[s] = d;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                done_prev[s] = 1'b0;
                busy_cnt[s]  = 0;
            end
        end else begin
            mon_step(0, done, busy, plaintext);
            mon_step(1, done_nc, busy_nc, pt_nc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input int s, input logic [63:0] pt, input int lat);
        exp_t e;
        e.pt  = pt;
        e.lat = lat;
        e.acc = cyc;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_done(input int s);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (s == 0) ? done : done_nc;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: inst %0d done not seen within 200 cycles", s);
        end
    endtask

    task automatic do_op(input int s, input logic [79:0] k, input logic [63:0] ct,
                         input logic [63:0] pt, input int lat);
        @(negedge clk);
        mkey       = k;
        ciphertext = ct;
        if (s == 0) start = 1'b1;
        else        start_nc = 1'b1;
        @(posedge clk);
        #1;
        push_exp(s, pt, lat);
        start    = 1'b0;
        start_nc = 1'b0;
        wait_done(s);
    endtask

    localparam logic [79:0] K_ONES = 80'hFFFFFFFFFFFFFFFFFFFF;
    localparam logic [79:0] K_A    = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] K_B    = 80'hA5A55A5AC3C33C3C9669;
    localparam logic [63:0] P_A    = 64'h0123456789ABCDEF;
    localparam logic [63:0] P_B1   = 64'h1122334455667788;
    localparam logic [63:0] P_B2   = 64'hDEADBEEFCAFEF00D;

    initial begin
        logic [95:0] rk;
        logic [79:0] k;
        logic [63:0] p;

        rst_n      = 1'b0;
        start      = 1'b0;
        start_nc   = 1'b0;
        mkey       = '0;
        ciphertext = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 80'(busy), 80'(0));
        check("reset_done", 80'(done), 80'(0));
        check("reset_plaintext", 80'(plaintext), 80'(0));
        check("reset_busy_nc", 80'(busy_nc), 80'(0));
        rst_n = 1'b1;

        // Published PRESENT-80 vectors.
        do_op(0, 80'h0, 64'h5579C1387B228445, 64'h0, 62);
        do_op(0, K_ONES, 64'hE72C46C0F5945049, 64'h0, 62);
        do_op(0, K_ONES, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 31);
        do_op(1, K_ONES, 64'hE72C46C0F5945049, 64'h0, 62);
        do_op(1, K_ONES, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 62);
        do_op(0, 80'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 62);
        do_op(0, K_A, encrypt(P_A, K_A), P_A, 62);

        // start held high with ciphertext churning mid-operation.
        @(negedge clk);
        mkey       = K_B;
        ciphertext = encrypt(P_B1, K_B);
        start      = 1'b1;
        @(posedge clk);
        #1;
        push_exp(0, P_B1, 62);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ciphertext = {$urandom(), $urandom()};
        end
        ciphertext = encrypt(P_B2, K_B);
        wait_done(0);
        @(posedge clk);
        #1;
        push_exp(0, P_B2, 31);
        check("done_drop_on_accept", 80'(done), 80'(0));
        check("busy_on_accept", 80'(busy), 80'(1));
        start = 1'b0;
        wait_done(0);

        // Reset 20 cycles into a cache-hit decrypt; cache must be lost.
        @(negedge clk);
        mkey       = K_B;
        ciphertext = encrypt(P_B2, K_B);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("busy_before_rst", 80'(busy), 80'(1));
        rst_n = 1'b0;
        #1;
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_done", 80'(done), 80'(0));
        check("rst_plaintext", 80'(plaintext), 80'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(0, K_B, encrypt(P_B2, K_B), P_B2, 62);

        // Random pairs; every second op reuses the previous key and should hit the cache.
        k = '0;
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) begin
                rk = {$urandom(), $urandom(), $urandom()};
                k  = rk[79:0];
            end
            p = {$urandom(), $urandom()};
            do_op(0, k, encrypt(p, k), p, (i % 2 == 0) ? 62 : 31);
        end

        repeat (5) @(negedge clk);
        check("q0_drained", 80'(q0.size()), 80'(0));
        check("q1_drained", 80'(q1.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
